// File: rtl/wb_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_pkg
// Brief   : Shared widths and grant-source encoding for the writeback arbiter.
// Rev     : 1.0
// ============================================================================
package wb_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_ALU  = 2'd1,
    WB_SRC_MEM  = 2'd2
  } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/wb_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : wb_write_arbiter_if
// Brief   : Result channels, register-file write port and bypass lookup.
// Rev     : 1.0
// ============================================================================
interface wb_write_arbiter_if #(
  parameter int XLEN   = wb_pkg::XLEN,
  parameter int REG_AW = wb_pkg::REG_AW
);

  logic              alu_valid;
  logic              alu_ready;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_wd;

  logic              mem_valid;
  logic              mem_ready;
  logic [REG_AW-1:0] mem_rd;
  logic [XLEN-1:0]   mem_wd;

  logic              rf_we;
  logic [REG_AW-1:0] rf_rd;
  logic [XLEN-1:0]   rf_wd;
  logic [31:0]       wb_count;

  logic [REG_AW-1:0] byp_rs1;
  logic [REG_AW-1:0] byp_rs2;
  logic              byp_hit1;
  logic              byp_hit2;
  logic [XLEN-1:0]   byp_data1;
  logic [XLEN-1:0]   byp_data2;

  // The arbiter side
  modport master (
    input  alu_valid, alu_rd, alu_wd,
    input  mem_valid, mem_rd, mem_wd,
    input  byp_rs1, byp_rs2,
    output alu_ready, mem_ready,
    output rf_we, rf_rd, rf_wd, wb_count,
    output byp_hit1, byp_hit2, byp_data1, byp_data2
  );

  // The producers / register file / decode side
  modport slave (
    output alu_valid, alu_rd, alu_wd,
    output mem_valid, mem_rd, mem_wd,
    output byp_rs1, byp_rs2,
    input  alu_ready, mem_ready,
    input  rf_we, rf_rd, rf_wd, wb_count,
    input  byp_hit1, byp_hit2, byp_data1, byp_data2
  );

endinterface
`default_nettype wire

// File: rtl/wb_write_arbiter_grant.sv
`default_nettype none
// ============================================================================
// Module  : wb_grant
// Brief   : Mem-first grant with a starvation counter that forces an ALU win.
// Rev     : 1.0
// ============================================================================
module wb_grant
  import wb_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    alu_valid,
  input  logic    mem_valid,
  output wb_src_e grant,
  output logic    alu_ready,
  output logic    mem_ready
);

  localparam logic [STARVE_W-1:0] C_STARVE_MAX = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] r_starve_cnt;
  logic [STARVE_W-1:0] w_starve_nxt;
  wb_src_e             w_grant;

  always_comb begin
    w_grant      = WB_SRC_NONE;
    w_starve_nxt = '0;
    // Nothing may be accepted while reset is held, or it would be lost.
    if (reset_n) begin
      if (alu_valid && mem_valid) begin
        w_grant = (r_starve_cnt == C_STARVE_MAX) ? WB_SRC_ALU : WB_SRC_MEM;
      end else if (alu_valid) begin
        w_grant = WB_SRC_ALU;
      end else if (mem_valid) begin
        w_grant = WB_SRC_MEM;
      end
    end
    if (alu_valid && (w_grant == WB_SRC_MEM)) begin
      w_starve_nxt = (r_starve_cnt == C_STARVE_MAX) ? r_starve_cnt
                                                    : r_starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
    end
  end

  assign grant     = w_grant;
  assign alu_ready = (w_grant == WB_SRC_ALU);
  assign mem_ready = (w_grant == WB_SRC_MEM);

endmodule
`default_nettype wire

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : wb_write_arbiter
// Brief   : Arbitrates ALU/load results onto the register-file write port.
//           Define WB_BYPASS_EN to enable the write-port bypass outputs.
// Rev     : 1.0
// ============================================================================
module wb_write_arbiter #(
  parameter int XLEN       = wb_pkg::XLEN,
  parameter int REG_AW     = wb_pkg::REG_AW,
  parameter int STARVE_MAX = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  wb_write_arbiter_if.master   bus
);

  import wb_pkg::*;

  wb_src_e           w_grant;
  logic              w_alu_ready;
  logic              w_mem_ready;
  logic              w_fire;
  logic [REG_AW-1:0] w_rd;
  logic [XLEN-1:0]   w_wd;

  logic              r_rf_we;
  logic [REG_AW-1:0] r_rf_rd;
  logic [XLEN-1:0]   r_rf_wd;
  logic [31:0]       r_wb_count;

  wb_grant #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .clk       (clk),
    .reset_n   (reset_n),
    .alu_valid (bus.alu_valid),
    .mem_valid (bus.mem_valid),
    .grant     (w_grant),
    .alu_ready (w_alu_ready),
    .mem_ready (w_mem_ready)
  );

  assign w_fire = (w_grant != WB_SRC_NONE);
  assign w_rd   = (w_grant == WB_SRC_ALU) ? bus.alu_rd : bus.mem_rd;
  assign w_wd   = (w_grant == WB_SRC_ALU) ? bus.alu_wd : bus.mem_wd;

  // x0 writes are accepted and counted but never reach the port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rf_we    <= 1'b0;
      r_rf_rd    <= '0;
      r_rf_wd    <= '0;
      r_wb_count <= '0;
    end else begin
      r_rf_we <= w_fire && (w_rd != REG_AW'(REG_ZERO));
      if (w_fire && (w_rd != REG_AW'(REG_ZERO))) begin
        r_rf_rd <= w_rd;
        r_rf_wd <= w_wd;
      end
      if (w_fire) begin
        r_wb_count <= r_wb_count + 32'd1;
      end
    end
  end

  assign bus.alu_ready = w_alu_ready;
  assign bus.mem_ready = w_mem_ready;
  assign bus.rf_we     = r_rf_we;
  assign bus.rf_rd     = r_rf_rd;
  assign bus.rf_wd     = r_rf_wd;
  assign bus.wb_count  = r_wb_count;

`ifdef WB_BYPASS_EN
  // The array only absorbs the write at the end of the rf_we cycle.
  assign bus.byp_hit1  = r_rf_we && (r_rf_rd == bus.byp_rs1) &&
                         (bus.byp_rs1 != REG_AW'(REG_ZERO));
  assign bus.byp_hit2  = r_rf_we && (r_rf_rd == bus.byp_rs2) &&
                         (bus.byp_rs2 != REG_AW'(REG_ZERO));
  assign bus.byp_data1 = r_rf_wd;
  assign bus.byp_data2 = r_rf_wd;
`else
  logic w_unused_byp;
  assign w_unused_byp  = ^{bus.byp_rs1, bus.byp_rs2};
  assign bus.byp_hit1  = 1'b0;
  assign bus.byp_hit2  = 1'b0;
  assign bus.byp_data1 = '0;
  assign bus.byp_data2 = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_write_arbiter
// Brief   : Directed vector bench for wb_write_arbiter.
// Rev     : 1.0
// ============================================================================
module tb_wb_write_arbiter;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  wb_write_arbiter_if bus ();

  wb_write_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] awd;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mwd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        ear;
    logic        emr;
    logic        ewe;
    logic [4:0]  erd;
    logic [31:0] ewd;
    logic [31:0] ecnt;
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];

  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  logic        e_hit1;
  logic        e_hit2;
  logic [31:0] e_d1;
  logic [31:0] e_d2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] awd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mwd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_wd    = awd;
    bus.mem_valid = mv;
    bus.mem_rd    = mrd;
    bus.mem_wd    = mwd;
    bus.byp_rs1   = rs1;
    bus.byp_rs2   = rs2;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //           av  ard    awd            mv  mrd    mwd           rs1    rs2   ear  emr  ewe  erd    ewd            ecnt
    vt[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        32'd0};
    vt[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,       5'd5,  5'd0, 1'b1, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 32'd1};
    vt[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       5'd5,  5'd0, 1'b0, 1'b0, 1'b0, 5'd5,  32'hDEADBEEF, 32'd1};
    vt[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h1234,    5'd5,  5'd5, 1'b0, 1'b1, 1'b0, 5'd5,  32'hDEADBEEF, 32'd2};
    vt[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'h33,      5'd3,  5'd3, 1'b0, 1'b1, 1'b1, 5'd3,  32'h33,       32'd3};
    vt[5]  = '{1'b1, 5'd10, 32'hA1,       1'b1, 5'd20, 32'hB1,      5'd3,  5'd0, 1'b0, 1'b1, 1'b1, 5'd20, 32'hB1,       32'd4};
    vt[6]  = '{1'b1, 5'd10, 32'hA1,       1'b1, 5'd21, 32'hB2,      5'd0,  5'd20,1'b0, 1'b1, 1'b1, 5'd21, 32'hB2,       32'd5};
    vt[7]  = '{1'b1, 5'd10, 32'hA1,       1'b1, 5'd22, 32'hB3,      5'd20, 5'd21,1'b0, 1'b1, 1'b1, 5'd22, 32'hB3,       32'd6};
    vt[8]  = '{1'b1, 5'd10, 32'hA1,       1'b1, 5'd23, 32'hB4,      5'd22, 5'd1, 1'b1, 1'b0, 1'b1, 5'd10, 32'hA1,       32'd7};
    vt[9]  = '{1'b1, 5'd11, 32'hA2,       1'b1, 5'd23, 32'hB4,      5'd0,  5'd10,1'b0, 1'b1, 1'b1, 5'd23, 32'hB4,       32'd8};
    vt[10] = '{1'b1, 5'd11, 32'hA2,       1'b1, 5'd24, 32'hB5,      5'd23, 5'd23,1'b0, 1'b1, 1'b1, 5'd24, 32'hB5,       32'd9};
    vt[11] = '{1'b1, 5'd11, 32'hA2,       1'b1, 5'd25, 32'hB6,      5'd2,  5'd3, 1'b0, 1'b1, 1'b1, 5'd25, 32'hB6,       32'd10};
    vt[12] = '{1'b1, 5'd11, 32'hA2,       1'b1, 5'd26, 32'hB7,      5'd25, 5'd0, 1'b1, 1'b0, 1'b1, 5'd11, 32'hA2,       32'd11};
    vt[13] = '{1'b1, 5'd0,  32'h77,       1'b0, 5'd0,  32'h0,       5'd11, 5'd11,1'b1, 1'b0, 1'b0, 5'd11, 32'hA2,       32'd12};
    vt[14] = '{1'b1, 5'd7,  32'hA5A5A5A5, 1'b1, 5'd0,  32'h55,      5'd11, 5'd0, 1'b0, 1'b1, 1'b0, 5'd11, 32'hA2,       32'd13};
    vt[15] = '{1'b1, 5'd7,  32'hA5A5A5A5, 1'b0, 5'd0,  32'h0,       5'd0,  5'd0, 1'b1, 1'b0, 1'b1, 5'd7,  32'hA5A5A5A5, 32'd14};
    vt[16] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       5'd7,  5'd0, 1'b0, 1'b0, 1'b0, 5'd7,  32'hA5A5A5A5, 32'd14};

    // Reset held with arbitrary traffic on the inputs.
    reset_n = 1'b0;
    drive(1'b1, 5'($urandom), $urandom, 1'b1, 5'($urandom), $urandom, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      drive(1'b1, 5'($urandom), $urandom, 1'b1, 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
      #1;
      chk("rst_ready", {30'd0, bus.alu_ready, bus.mem_ready}, 32'd0);
      chk("rst_we", {31'd0, bus.rf_we}, 32'd0);
      chk("rst_rd_wd", {27'd0, bus.rf_rd} | bus.rf_wd, 32'd0);
      chk("rst_count", bus.wb_count, 32'd0);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_we", {31'd0, bus.rf_we}, 32'd0);
    chk("post_rst_rd", {27'd0, bus.rf_rd}, 32'd0);
    chk("post_rst_wd", bus.rf_wd, 32'd0);
    chk("post_rst_count", bus.wb_count, 32'd0);
    chk("post_rst_starve", {28'd0, dut.u_grant.r_starve_cnt}, 32'd0);

    m_we = 1'b0;
    m_rd = 5'd0;
    m_wd = 32'h0;
    for (int i = 0; i < NV; i++) begin
      drive(vt[i].av, vt[i].ard, vt[i].awd, vt[i].mv, vt[i].mrd, vt[i].mwd, vt[i].rs1, vt[i].rs2);
`ifdef WB_BYPASS_EN
      e_hit1 = m_we && (m_rd == vt[i].rs1) && (vt[i].rs1 != 5'd0);
      e_hit2 = m_we && (m_rd == vt[i].rs2) && (vt[i].rs2 != 5'd0);
      e_d1   = m_wd;
      e_d2   = m_wd;
`else
      e_hit1 = 1'b0;
      e_hit2 = 1'b0;
      e_d1   = 32'h0;
      e_d2   = 32'h0;
`endif
      #1;
      chk($sformatf("v%0d_alu_ready", i), {31'd0, bus.alu_ready}, {31'd0, vt[i].ear});
      chk($sformatf("v%0d_mem_ready", i), {31'd0, bus.mem_ready}, {31'd0, vt[i].emr});
      chk($sformatf("v%0d_byp_hit1", i), {31'd0, bus.byp_hit1}, {31'd0, e_hit1});
      chk($sformatf("v%0d_byp_hit2", i), {31'd0, bus.byp_hit2}, {31'd0, e_hit2});
      chk($sformatf("v%0d_byp_data1", i), bus.byp_data1, e_d1);
      chk($sformatf("v%0d_byp_data2", i), bus.byp_data2, e_d2);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rf_we", i), {31'd0, bus.rf_we}, {31'd0, vt[i].ewe});
      chk($sformatf("v%0d_rf_rd", i), {27'd0, bus.rf_rd}, {27'd0, vt[i].erd});
      chk($sformatf("v%0d_rf_wd", i), bus.rf_wd, vt[i].ewd);
      chk($sformatf("v%0d_wb_count", i), bus.wb_count, vt[i].ecnt);
      m_we = vt[i].ewe;
      m_rd = vt[i].erd;
      m_wd = vt[i].ewd;
    end

    // Build up some starvation, then lose an ALU grant to an async reset.
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd4, 32'h44, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    chk("mid_pre_starve", {28'd0, dut.u_grant.r_starve_cnt}, 32'd1);
    chk("mid_pre_count", bus.wb_count, 32'd15);
    drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1;
    chk("mid_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_count", bus.wb_count, 32'd0);
    chk("mid_rst_starve", {28'd0, dut.u_grant.r_starve_cnt}, 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("mid_rst_we", {31'd0, bus.rf_we}, 32'd0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("mid_post_we", {31'd0, bus.rf_we}, 32'd0);
      chk("mid_post_count", bus.wb_count, 32'd0);
      chk("mid_post_rd", {27'd0, bus.rf_rd}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writeback-side driver of the register-file write port, the producer end of the `we`/`rd`/`wd` interface.
- Arbitrates completed results from the ALU path and the load/memory path onto the single write port. One write per cycle; fixed priority with an anti-starvation override.
- Registers the chosen write for one cycle and keeps a retired-write counter.
- Optional bypass outputs cover the cycle in which a write is visible on the port but not yet in the array.

Parameters:
- XLEN, 32, data width of results and write data
- REG_AW, 5, register address width
- STARVE_MAX, 3, consecutive ALU losses before the ALU is forced a grant (1..15)

Ports:
- clk  in  1  clock, all state on posedge
- reset_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  ALU result accepted this cycle
- alu_rd  in  REG_AW  ALU destination register
- alu_wd  in  XLEN  ALU result
- mem_valid  in  1  load result valid
- mem_ready  out  1  load result accepted this cycle
- mem_rd  in  REG_AW  load destination register
- mem_wd  in  XLEN  load data
- rf_we  out  1  register-file write enable (registered)
- rf_rd  out  REG_AW  register-file write address (registered)
- rf_wd  out  XLEN  register-file write data (registered)
- wb_count  out  32  number of results accepted since reset
- byp_rs1, byp_rs2  in  REG_AW  decode-stage read addresses
- byp_hit1, byp_hit2  out  1  bypass hit per read port
- byp_data1, byp_data2  out  XLEN  bypass data per read port

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset_n` is asynchronous and active-low. While low, these outputs are 0: rf_we, rf_rd, rf_wd, wb_count. The starvation counter is also 0.
- Handshake: a transfer occurs when valid && ready in the same cycle.
  - Ready is combinational from the valids and the starvation counter.
  - Sources must not depend on ready to raise valid.
  - Once valid is asserted, payload must stay stable until it is accepted.
- Grant, evaluated each cycle:
  - Neither source valid: no grant.
  - One source valid: that source is granted.
  - Both valid: mem is granted, unless starve_cnt == STARVE_MAX, in which case alu is granted.
  - At most one ready is high per cycle.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on each cycle where alu_valid=1 and mem is granted.
  - Clears when alu is granted or alu_valid=0.
- Latency: a grant in cycle N gives rf_we/rf_rd/rf_wd in cycle N+1. rf_we is high for exactly one cycle per non-x0 grant. There is no back-pressure from the register file.
- x0 handling: a granted result with rd == 0 is still accepted (ready=1) and still counts in wb_count. rf_we stays 0 for it; rf_rd and rf_wd hold their previous values.
- rf_rd and rf_wd update only on non-x0 grants and hold otherwise.
- wb_count increments by 1 on every grant, registered. It wraps at 2^32 to 0.
- Reset mid-operation: a grant taken in the cycle reset_n falls is discarded. No rf_we pulse follows; the counters clear.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: byp_hitK = rf_we && (rf_rd == byp_rsK) && (byp_rsK != 0), and byp_dataK = rf_wd, both combinational. This covers the read-during-write cycle, since the array updates only at the end of the cycle in which rf_we is high.
- Undefined: byp_hit1, byp_hit2, byp_data1 and byp_data2 are tied 0. The ports remain for a stable interface.

Decomposition:
- Shared package wb_pkg:
  - XLEN, REG_AW, REG_ZERO (5'd0)
  - source enum wb_src_e {WB_SRC_NONE, WB_SRC_ALU, WB_SRC_MEM}
  - STARVE_W = 4
- One sub-module, wb_grant: the combinational grant plus the starve_cnt register. It outputs wb_src_e grant, alu_ready and mem_ready.
- The top level holds the output register, wb_count and the bypass.

Test Plan:
- Reset: drive reset_n=0 with random inputs -> rf_we=0, rf_rd=0, rf_wd=0, wb_count=0, alu_ready=mem_ready=0. Release -> all outputs still 0.
- Single ALU write: alu_valid=1, alu_rd=5, alu_wd=0xDEADBEEF for one cycle -> alu_ready=1 that cycle. Next cycle rf_we=1, rf_rd=5, rf_wd=0xDEADBEEF. The cycle after, rf_we=0 and wb_count=1.
- Contention, STARVE_MAX=3: both valid continuously with distinct rd -> grant sequence M,M,M,A,M,M,M,A. rf_rd matches the sequence with one-cycle lag.
- x0 drop: mem_valid=1, mem_rd=0, mem_wd=0x1234 -> mem_ready=1, rf_we stays 0 next cycle, rf_rd and rf_wd unchanged, wb_count increments by 1.
- Async reset mid-op: grant alu_rd=9, then pull reset_n low before the next posedge -> rf_we never pulses, wb_count=0, starve_cnt=0.
- Bypass with WB_BYPASS_EN:
  - rf_we=1, rf_rd=7, rf_wd=0xA5A5A5A5, byp_rs1=7, byp_rs2=0 -> byp_hit1=1, byp_data1=0xA5A5A5A5, byp_hit2=0.
  - Same stimulus with the macro undefined -> all byp outputs 0.
